// File: rtl/span_fill.sv
// Scanline span filler: latches one span per line and renders 256 pixels into a
// ping-pong line buffer while scan-out reads the opposite bank.
module span_fill #(
    parameter int PIX_W = 4
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             line_start,
    input  logic [7:0]       span_x_start,
    input  logic [7:0]       span_x_end,
    input  logic             span_active,
    input  logic [PIX_W-1:0] fill_color,
    input  logic [PIX_W-1:0] bg_color,
    input  logic [7:0]       rd_x,
    output logic [PIX_W-1:0] rd_pix,
    output logic             busy,
    output logic             overrun,
    input  logic             ovr_clr
);

    typedef enum logic {IDLE, FILL} state_t;

    state_t           state, state_nx;
    logic [7:0]       x, x_nx;
    logic [7:0]       lo, lo_nx, hi, hi_nx;
    logic             act, act_nx;
    logic [PIX_W-1:0] fill_c, fill_nx, bg_c, bg_nx;
    logic             fill_bank, bank_nx;
    logic             ovr_nx;
    logic             last;
    logic             wr_en;
    logic [PIX_W-1:0] wr_data;

    logic [PIX_W-1:0] mem [2][256];

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state     <= IDLE;
            x         <= '0;
            lo        <= '0;
            hi        <= '0;
            act       <= 1'b0;
            fill_c    <= '0;
            bg_c      <= '0;
            fill_bank <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nx;
            x         <= x_nx;
            lo        <= lo_nx;
            hi        <= hi_nx;
            act       <= act_nx;
            fill_c    <= fill_nx;
            bg_c      <= bg_nx;
            fill_bank <= bank_nx;
            overrun   <= ovr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        x_nx     = x;
        lo_nx    = lo;
        hi_nx    = hi;
        act_nx   = act;
        fill_nx  = fill_c;
        bg_nx    = bg_c;
        bank_nx  = fill_bank;
        ovr_nx   = overrun;
        wr_en    = 1'b0;
        last     = (x == 8'hFF);

        if (ovr_clr)
            ovr_nx = 1'b0;

        // A restart on the final pixel still commits it and is not an overrun.
        if (state == FILL && (!line_start || last))
            wr_en = 1'b1;

        if (line_start) begin
            if (state == FILL && !last)
                ovr_nx = 1'b1;
            bank_nx  = ~fill_bank;
            lo_nx    = (span_x_start < span_x_end) ? span_x_start : span_x_end;
            hi_nx    = (span_x_start < span_x_end) ? span_x_end : span_x_start;
            act_nx   = span_active;
            fill_nx  = fill_color;
            bg_nx    = bg_color;
            x_nx     = '0;
            state_nx = FILL;
        end else if (state == FILL) begin
            x_nx = x + 8'd1;
            if (last)
                state_nx = IDLE;
        end
    end

    assign wr_data = (act && x >= lo && x <= hi) ? fill_c : bg_c;
    assign busy    = (state == FILL);

    always_ff @(posedge wb_clk_i) begin
        if (wr_en)
            mem[fill_bank][x] <= wr_data;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni)
            rd_pix <= '0;
        else
            rd_pix <= mem[~fill_bank][rd_x];
    end

endmodule

// File: tb/tb_span_fill.sv
// Randomised bench for span_fill: a line-level reference model tracks which
// bank holds which completed line and predicts busy, overrun and rd_pix.
module tb_span_fill;

    localparam int PW = 4;

    logic          clk;
    logic          rst_n;
    logic          line_start;
    logic [7:0]    xa, xb;
    logic          active;
    logic [PW-1:0] fc, bc;
    logic [7:0]    rd_x;
    logic [PW-1:0] rd_pix;
    logic          busy;
    logic          overrun;
    logic          ovr_clr;

    span_fill #(.PIX_W(PW)) dut (
        .wb_clk_i     (clk),
        .wb_rst_ni    (rst_n),
        .line_start   (line_start),
        .span_x_start (xa),
        .span_x_end   (xb),
        .span_active  (active),
        .fill_color   (fc),
        .bg_color     (bc),
        .rd_x         (rd_x),
        .rd_pix       (rd_pix),
        .busy         (busy),
        .overrun      (overrun),
        .ovr_clr      (ovr_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model: whole lines, which bank is filling, pixels done so far.
    logic [PW-1:0] m_mem  [2][256];
    bit            m_val  [2][256];
    logic [PW-1:0] m_line [256];
    int            m_bank;
    bit            m_busy;
    int            m_cnt;
    bit            m_ovr;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bank = 0;
        m_busy = 0;
        m_cnt  = 0;
        m_ovr  = 0;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 256; i++)
                m_val[b][i] = 0;
    endtask

    task automatic commit();
        for (int i = 0; i < 256; i++) begin
            m_mem[m_bank][i] = m_line[i];
            m_val[m_bank][i] = 1;
        end
    endtask

    // One clock: capture inputs, advance model across the edge, check outputs.
    task automatic step();
        bit            ls, clr, ac, chk, set_ovr;
        int            a, b, lo, hi, disp;
        logic [PW-1:0] f, g, exp_rd;
        ls   = line_start;
        clr  = ovr_clr;
        a    = int'(xa);
        b    = int'(xb);
        ac   = active;
        f    = fc;
        g    = bc;
        disp = 1 - m_bank;
        chk  = m_val[disp][rd_x];
        exp_rd = m_mem[disp][rd_x];
        @(posedge clk);
        #1;
        set_ovr = 0;
        if (ls) begin
            if (m_busy && m_cnt == 255) commit();
            else if (m_busy) set_ovr = 1;
            m_bank = 1 - m_bank;
            for (int i = 0; i < 256; i++) m_val[m_bank][i] = 0;
            lo = (a < b) ? a : b;
            hi = (a < b) ? b : a;
            for (int i = 0; i < 256; i++)
                m_line[i] = (ac && i >= lo && i <= hi) ? f : g;
            m_busy = 1;
            m_cnt  = 0;
        end else if (m_busy) begin
            m_cnt++;
            if (m_cnt == 256) begin
                commit();
                m_busy = 0;
            end
        end
        if (set_ovr) m_ovr = 1;
        else if (clr) m_ovr = 0;
        check("busy", 8'(busy), 8'(m_busy));
        check("overrun", 8'(overrun), 8'(m_ovr));
        if (chk) check("rd_pix", 8'(rd_pix), 8'(exp_rd));
        line_start = 1'b0;
        ovr_clr    = 1'b0;
    endtask

    function automatic logic [7:0] rd_sel(input int mode, input int k);
        logic [7:0] r;
        case (mode)
            0:       r = 8'(k);
            1:       r = 8'd5;
            default: r = 8'($urandom_range(0, 255));
        endcase
        return r;
    endfunction

    // Pulse line_start, then run until just before the next pulse would land.
    task automatic run_line(input int a, input int b, input bit ac, input int f,
                            input int g, input int gap, input int mode);
        xa = 8'(a); xb = 8'(b); active = ac; fc = PW'(f); bc = PW'(g);
        line_start = 1'b1;
        rd_x = rd_sel(mode, 0);
        step();
        for (int k = 1; k < gap; k++) begin
            xa = 8'($urandom); xb = 8'($urandom); active = 1'($urandom);
            fc = PW'($urandom); bc = PW'($urandom);
            rd_x = rd_sel(mode, k);
            step();
        end
    endtask

    task automatic rand_line(input int gap, input int mode);
        run_line($urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom),
                 $urandom_range(0, 15), $urandom_range(0, 15), gap, mode);
    endtask

    // Drop reset between edges, confirm outputs clear without a clock.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_busy", 8'(busy), 8'd0);
        check("rst_overrun", 8'(overrun), 8'd0);
        check("rst_rd_pix", 8'(rd_pix), 8'd0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            check("rst_hold_busy", 8'(busy), 8'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; line_start = 1'b0; ovr_clr = 1'b0;
        xa = '0; xb = '0; active = 1'b0; fc = '0; bc = '0; rd_x = '0;
        model_reset();
        #1;
        check("init_busy", 8'(busy), 8'd0);
        check("init_overrun", 8'(overrun), 8'd0);
        check("init_rd_pix", 8'(rd_pix), 8'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic, reversed, single-pixel, full, inactive lines; sweep reads.
        run_line(10, 20, 1, 4'hA, 4'h1, 256, 0);
        run_line(200, 50, 1, 4'h5, 4'h2, 256, 0);
        run_line(8'h7F, 8'h7F, 1, 4'hC, 4'h3, 256, 0);
        run_line(0, 255, 1, 4'h6, 4'h0, 256, 0);
        run_line(0, 255, 0, 4'h9, 4'h4, 256, 0);
        run_line(3, 3, 1, 4'hE, 4'h7, 256, 0);
        repeat (4) rand_line(256, 2);

        // Overrun, clear, clear coincident with new overrun, clean restart.
        rand_line(100, 2);
        rand_line(50, 2);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b1;
        rand_line(256, 2);
        rand_line(256, 0);
        ovr_clr = 1'b1;
        step();
        rand_line(256 + $urandom_range(0, 20), 0);

        // Swap boundary with rd_x held, three distinct colours.
        run_line(0, 255, 1, 4'h1, 4'h0, 256, 1);
        run_line(0, 255, 1, 4'h2, 4'h0, 256, 1);
        run_line(0, 255, 1, 4'h3, 4'h0, 256, 1);
        run_line(4, 6, 1, 4'hB, 4'h8, 300, 1);

        // Async reset mid-fill, then behave as first line after reset.
        rand_line(129, 2);
        async_reset();
        run_line(10, 20, 1, 4'hA, 4'h1, 256, 0);
        run_line(30, 40, 1, 4'hD, 4'h2, 256, 0);
        rand_line(260, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
